// File: rtl/d2x4_seq.sv
// Registered one-hot decoder with an optional automatic code sweep.
// The sweep FSM is compiled in only when D2X4_SEQ_SWEEP_EN is defined.
module d2x4_seq #(
    parameter int SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sweep_start,
    output logic [(2**SEL_W)-1:0]   D,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    sweep_done
);

    localparam int OUT_W = 2**SEL_W;

    logic [OUT_W-1:0] d_q, d_d;
    logic             out_valid_q, out_valid_d;

    assign D         = d_q;
    assign out_valid = out_valid_q;

`ifdef D2X4_SEQ_SWEEP_EN
    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(OUT_W - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;

    assign busy       = (state_q == SWEEP);
    assign in_ready   = en & ~busy & ~sweep_start;
    // out_valid_q is low while a blanked sweep waits to resume, so no early pulse.
    assign sweep_done = busy & out_valid_q & (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        if (!en) begin
            d_d         = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        state_d     = SWEEP;
                        cnt_d       = '0;
                        d_d         = OUT_W'(1);
                        out_valid_d = 1'b1;
                    end else if (in_valid) begin
                        d_d         = OUT_W'(1) << sel;
                        out_valid_d = 1'b1;
                    end
                end
                SWEEP: begin
                    if (!out_valid_q) begin
                        // Resuming after a blanked interval: re-show the held code.
                        d_d         = OUT_W'(1) << cnt_q;
                        out_valid_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        d_d   = OUT_W'(1) << cnt_d;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_sweep;

    assign unused_sweep = sweep_start;
    assign busy         = 1'b0;
    assign sweep_done   = 1'b0;
    assign in_ready     = en;

    always_comb begin
        d_d         = d_q;
        out_valid_d = out_valid_q;
        if (!en) begin
            d_d         = '0;
            out_valid_d = 1'b0;
        end else if (in_valid) begin
            d_d         = OUT_W'(1) << sel;
            out_valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
